// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The requester uses the master modport; the divider uses the slave modport.
interface seq_restoring_divider_if #(
  parameter int N = 6
);

  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [2*N-1:0] q;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;
  logic           dbz;

  modport master (
    output start, dividend, divisor,
    input  q, r, busy, done, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output q, r, busy, done, dbz
  );

endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, start/busy/done handshake, divide-by-zero flagged separately.
// All outputs are driven straight from registers.
module seq_restoring_divider #(
  parameter int N = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_restoring_divider_if.slave bus
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t        state, state_next;

  // Dividend shift register: quotient bits enter at the LSB as dividend bits
  // leave at the MSB, so after 2N iterations it holds the quotient.
  logic [W-1:0]  d_reg, d_next;
  logic [N-1:0]  v_reg, v_next;
  // The partial remainder is always below the divisor after the restore step,
  // so its top bit is zero and only N bits are kept; the N+1-bit width lives
  // in the trial value t.
  logic [N-1:0]  p_reg, p_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          zero_reg, zero_next;

  logic [W-1:0]  q_reg, q_next;
  logic [N-1:0]  r_reg, r_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          dbz_reg, dbz_next;

  logic [N:0]    t;
  logic          fits;
  logic [N-1:0]  diff;

  // Trial remainder and compare; when t >= divisor the difference is below
  // the divisor, so N-bit modular subtraction gives the exact result.
  always_comb begin
    t    = {p_reg, d_reg[W-1]};
    fits = (t >= {1'b0, v_reg});
    diff = t[N-1:0] - v_reg;
  end

  // Next-state and datapath update for the IDLE/RUN/FIN sequence.
  always_comb begin
    state_next = state;
    d_next     = d_reg;
    v_next     = v_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    zero_next  = zero_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    dbz_next   = dbz_reg;

    case (state)
      IDLE: begin
        if (bus.start) begin
          d_next     = bus.dividend;
          v_next     = bus.divisor;
          p_next     = '0;
          cnt_next   = CW'(W);
          busy_next  = 1'b1;
          zero_next  = (bus.divisor == '0);
          state_next = (bus.divisor == '0) ? FIN : RUN;
        end
      end

      RUN: begin
        if (fits) begin
          p_next = diff;
          d_next = {d_reg[W-2:0], 1'b1};
        end else begin
          p_next = t[N-1:0];
          d_next = {d_reg[W-2:0], 1'b0};
        end
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          state_next = FIN;
        end
      end

      FIN: begin
        q_next     = zero_reg ? {W{1'b1}} : d_reg;
        r_next     = zero_reg ? '0 : p_reg;
        dbz_next   = zero_reg;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d_reg    <= '0;
      v_reg    <= '0;
      p_reg    <= '0;
      cnt_reg  <= '0;
      zero_reg <= 1'b0;
      q_reg    <= '0;
      r_reg    <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      d_reg    <= d_next;
      v_reg    <= v_next;
      p_reg    <= p_next;
      cnt_reg  <= cnt_next;
      zero_reg <= zero_next;
      q_reg    <= q_next;
      r_reg    <= r_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
      dbz_reg  <= dbz_next;
    end
  end

  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.dbz  = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (N=6): reset, hand-computed
// quotients/remainders, latency, divide-by-zero, ignored start, back-to-back,
// mid-operation reset, and a random identity sweep.
module tb_seq_restoring_divider;

  localparam int N = 6;
  localparam int NORMAL_LAT = 2 * N + 1;
  localparam int DBZ_LAT    = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   cyc;
  int   done_seen;
  int   dvd;
  int   dvs;

  seq_restoring_divider_if #(.N(N)) bus ();

  seq_restoring_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int qe, input int re, input int dbze);
    check({tag, "_q"},   32'(bus.q),   32'(qe));
    check({tag, "_r"},   32'(bus.r),   32'(re));
    check({tag, "_dbz"}, 32'(bus.dbz), 32'(dbze));
  endtask

  // Called at a negedge with the divider idle; returns at the negedge after
  // the accept edge with start dropped again.
  task automatic applyStimulus(input int a, input int b);
    bus.start    = 1'b1;
    bus.dividend = (2*N)'(a);
    bus.divisor  = N'(b);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Counts negedges until done is seen, bounded so a stuck DUT still ends.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Confirms done drops after one cycle.
  task automatic checkPulseEnd(input string tag);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    check("reset_q",    32'(bus.q),    32'd0);
    check("reset_r",    32'(bus.r),    32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_dbz",  32'(bus.dbz),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7 = 14 r 2, with latency and busy checks.
    applyStimulus(100, 7);
    check("basic_busy", 32'(bus.busy), 32'd1);
    waitDone(cyc);
    check("basic_latency", 32'(cyc), 32'(NORMAL_LAT));
    check("basic_busy_done", 32'(bus.busy), 32'd0);
    checkOutput("basic", 14, 2, 0);
    checkPulseEnd("basic");

    // 4095 / 63 = 65 r 0.
    applyStimulus(4095, 63);
    waitDone(cyc);
    checkOutput("max_by_63", 65, 0, 0);
    checkPulseEnd("max_by_63");

    // 4095 / 1 = 4095 r 0.
    applyStimulus(4095, 1);
    waitDone(cyc);
    checkOutput("max_by_1", 4095, 0, 0);
    checkPulseEnd("max_by_1");

    // 10 / 20 = 0 r 10.
    applyStimulus(10, 20);
    waitDone(cyc);
    checkOutput("small_dvd", 0, 10, 0);
    checkPulseEnd("small_dvd");

    // 0 / 5 = 0 r 0.
    applyStimulus(0, 5);
    waitDone(cyc);
    checkOutput("zero_dvd", 0, 0, 0);
    checkPulseEnd("zero_dvd");

    // 5 / 0: all-ones quotient, flag set, short latency.
    applyStimulus(5, 0);
    waitDone(cyc);
    check("dbz_latency", 32'(cyc), 32'(DBZ_LAT));
    checkOutput("dbz", 4095, 0, 1);
    checkPulseEnd("dbz");
    check("dbz_held", 32'(bus.dbz), 32'd1);

    // Following valid division clears the flag.
    applyStimulus(100, 7);
    check("dbz_hold_during_run", 32'(bus.dbz), 32'd1);
    waitDone(cyc);
    checkOutput("after_dbz", 14, 2, 0);
    checkPulseEnd("after_dbz");

    // Start pulsed mid-run with new operands must be ignored.
    applyStimulus(100, 7);
    repeat (3) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 12'd4095;
    bus.divisor  = 6'd1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(cyc);
    check("ignore_latency", 32'(cyc), 32'(NORMAL_LAT - 4));
    checkOutput("ignore", 14, 2, 0);

    // Start in the done cycle: zero-bubble back-to-back, old result held.
    applyStimulus(4095, 63);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_q_held", 32'(bus.q), 32'd14);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    waitDone(cyc);
    check("b2b_latency", 32'(cyc), 32'(NORMAL_LAT));
    checkOutput("b2b", 65, 0, 0);
    checkPulseEnd("b2b");
    check("b2b_idle_after", 32'(bus.busy), 32'd0);

    // Reset five cycles into an operation: no done, outputs cleared.
    applyStimulus(100, 7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort", 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Random sweep: q*divisor + r == dividend and r < divisor.
    for (int i = 0; i < 20; i++) begin
      dvd = int'($urandom_range(0, 4095));
      dvs = int'($urandom_range(1, 63));
      applyStimulus(dvd, dvs);
      waitDone(cyc);
      check("sweep_identity", 32'(int'(bus.q) * dvs + int'(bus.r)), 32'(dvd));
      check("sweep_rem_lt", 32'(int'(bus.r) < dvs), 32'd1);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
